sha256_msg_sched: RTL and testbench

- Sequences SHA-256 message-schedule expansion for one 512-bit block.
- Accepts 16 message words W[0..15] over a valid/ready input stream and passes them through.
- Then generates W[16..63] as σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] (mod 2^32), keeping the last 16 words in a circular buffer.
- Sits between the CFU request path and the round datapath; serves as the controller/feeder for the σ0/σ1 logic.

---
 rtl/sha256_sched_pkg.sv | 34 +++
 rtl/sha256_w_buf.sv | 39 +++
 rtl/sha256_msg_sched.sv | 202 ++++++++++++++++++++
 tb/tb_sha256_msg_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_sched_pkg.sv
// sha256_sched_pkg
//   Shared types, constants and SHA-256 small-sigma helpers for the
//   message-schedule feeder (sha256_msg_sched / sha256_w_buf).
//   Optional build macro used by the top: SHA256_SCHED_SIG_REG_EN.
package sha256_sched_pkg;

    localparam int WORD_W    = 32;
    localparam int BUF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] ror32(input logic [WORD_W-1:0] x,
                                                input int unsigned       n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] shr32(input logic [WORD_W-1:0] x,
                                                input int unsigned       n);
        return x >> n;
    endfunction

    function automatic logic [WORD_W-1:0] sigma0_32(input logic [WORD_W-1:0] x);
        return ror32(x, 7) ^ ror32(x, 18) ^ shr32(x, 3);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1_32(input logic [WORD_W-1:0] x);
        return ror32(x, 17) ^ ror32(x, 19) ^ shr32(x, 10);
    endfunction

endpackage

// File: rtl/sha256_w_buf.sv
// sha256_w_buf
//   16 x 32 circular buffer holding the last 16 schedule words.
//   One write port at slot t[3:0], four combinational read taps at
//   (t-2), (t-7), (t-15) and (t-16) mod 16.
//   Ports:
//     clk_i        clock
//     we_i         write enable
//     t_i          low 4 bits of the schedule index t
//     wdata_i      word written to slot t[3:0]
//     tap2_o..     W[t-2], W[t-7], W[t-15], W[t-16]
//   Contents are not reset. The t-16 tap aliases the write slot; the read
//   returns the old word while the new one lands on the clock edge.
module sha256_w_buf
    import sha256_sched_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        t_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] tap2_o,
    output logic [WORD_W-1:0] tap7_o,
    output logic [WORD_W-1:0] tap15_o,
    output logic [WORD_W-1:0] tap16_o
);

    logic [WORD_W-1:0] mem_q [BUF_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[t_i] <= wdata_i;
        end
    end

    assign tap2_o  = mem_q[t_i - 4'd2];
    assign tap7_o  = mem_q[t_i - 4'd7];
    assign tap15_o = mem_q[t_i - 4'd15];
    assign tap16_o = mem_q[t_i];

endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
//   SHA-256 message-schedule feeder for one 512-bit block. Passes W[0..15]
//   through from the input stream, then expands W[16..ROUNDS-1].
//   Parameter ROUNDS (17..64): words emitted per block.
//   Ports:
//     clk, rst (async, active low)
//     start     one-cycle start pulse, honoured in IDLE only
//     clear     synchronous abort back to IDLE
//     in_valid / in_ready / in_data    message word input stream
//     w_valid / w_ready / w_data / w_idx   schedule word output stream
//     busy      state != IDLE
//     done      registered pulse after the last word is accepted
//   Build macro SHA256_SCHED_SIG_REG_EN: adds a register stage for the
//   sigma terms, expansion then runs at one word per two cycles.
//
//   state  | meaning
//   -------+------------------------------------------------------
//   IDLE   | waiting for start, outputs quiet
//   LOAD   | accepting W[0..15] and passing them to the output
//   EXPAND | generating W[16..ROUNDS-1], leave on last handshake
module sha256_msg_sched
    import sha256_sched_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [5:0]        w_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [6:0] ROUNDS_T = 7'(ROUNDS);
    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_e            state_q, state_d;
    logic [6:0]        t_q, t_d;
    logic [WORD_W-1:0] w_data_q, w_data_d;
    logic [5:0]        w_idx_q, w_idx_d;
    logic              w_valid_q, w_valid_d;
    logic              done_q, done_d;

    logic              slot_free, in_hs, out_hs, last_hs;
    logic              gen_en;
    logic              buf_we;
    logic [WORD_W-1:0] buf_wdata, w_new;
    logic [WORD_W-1:0] tap2, tap7, tap15, tap16;

    assign slot_free = !w_valid_q || w_ready;
    assign in_ready  = (state_q == LOAD) && slot_free;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = w_valid_q && w_ready;
    assign last_hs   = (state_q == EXPAND) && out_hs && (w_idx_q == LAST_IDX);

    sha256_w_buf u_buf (
        .clk_i   (clk),
        .we_i    (buf_we),
        .t_i     (t_q[3:0]),
        .wdata_i (buf_wdata),
        .tap2_o  (tap2),
        .tap7_o  (tap7),
        .tap15_o (tap15),
        .tap16_o (tap16)
    );

`ifdef SHA256_SCHED_SIG_REG_EN
    // Sub-phase A (phase_q = 0) registers the four terms; sub-phase B adds
    // them once the output slot is free. A always follows the previous B,
    // so W[t-2] is already in the buffer when it is tapped.
    logic              phase_q;
    logic              cap_en;
    logic [WORD_W-1:0] s0_q, s1_q, w7_q, w16_q;

    assign cap_en = (state_q == EXPAND) && (t_q < ROUNDS_T) && !phase_q;
    assign gen_en = (state_q == EXPAND) && phase_q && slot_free;
    assign w_new  = s1_q + w7_q + s0_q + w16_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            w7_q    <= '0;
            w16_q   <= '0;
        end else if (clear) begin
            phase_q <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            w7_q    <= '0;
            w16_q   <= '0;
        end else if (cap_en) begin
            phase_q <= 1'b1;
            s0_q    <= sigma0_32(tap15);
            s1_q    <= sigma1_32(tap2);
            w7_q    <= tap7;
            w16_q   <= tap16;
        end else if (gen_en) begin
            phase_q <= 1'b0;
        end
    end
`else
    assign gen_en = (state_q == EXPAND) && (t_q < ROUNDS_T) && slot_free;
    assign w_new  = sigma1_32(tap2) + tap7 + sigma0_32(tap15) + tap16;
`endif

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        w_data_d  = w_data_q;
        w_idx_d   = w_idx_q;
        w_valid_d = w_valid_q;
        done_d    = 1'b0;
        buf_we    = 1'b0;
        buf_wdata = in_data;

        // A handshake empties the slot unless a new word is loaded below.
        if (out_hs) begin
            w_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    t_d     = '0;
                end
            end
            LOAD: begin
                if (in_hs) begin
                    buf_we    = 1'b1;
                    buf_wdata = in_data;
                    w_data_d  = in_data;
                    w_idx_d   = t_q[5:0];
                    w_valid_d = 1'b1;
                    t_d       = t_q + 7'd1;
                    if (t_q == 7'd15) begin
                        state_d = EXPAND;
                    end
                end
            end
            EXPAND: begin
                if (gen_en) begin
                    buf_we    = 1'b1;
                    buf_wdata = w_new;
                    w_data_d  = w_new;
                    w_idx_d   = t_q[5:0];
                    w_valid_d = 1'b1;
                    t_d       = t_q + 7'd1;
                end
                if (last_hs) begin
                    state_d = IDLE;
                    t_d     = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d   = IDLE;
            w_valid_d = 1'b0;
            t_d       = '0;
            done_d    = 1'b0;
            buf_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            t_q       <= '0;
            w_data_q  <= '0;
            w_idx_q   <= '0;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            w_data_q  <= w_data_d;
            w_idx_q   <= w_idx_d;
            w_valid_q <= w_valid_d;
            done_q    <= done_d;
        end
    end

    assign w_valid = w_valid_q;
    assign w_data  = w_data_q;
    assign w_idx   = w_idx_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

    typedef struct {
        string              name;
        logic [15:0][31:0]  w;
        int                 idx;
        logic [31:0]        exp;
    } vec_t;

    localparam int NV = 6;
    localparam int LIMIT = 400;
`ifdef SHA256_SCHED_SIG_REG_EN
    localparam int SPACING = 15 + 2 * 48;
`else
    localparam int SPACING = 63;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        w_ready = 1'b0;
    logic        in_ready, w_valid, busy, done;
    logic [31:0] w_data;
    logic [5:0]  w_idx;

    int          checks = 0;
    int          failures = 0;
    vec_t        vecs [NV];
    logic [31:0] exp_w [64];
    logic [31:0] got [64];
    logic [5:0]  gidx [64];
    int          first_cyc, last_cyc, stab_err, rdy_err;
    bit          aborted;

    sha256_msg_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .w_idx    (w_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_model(input logic [15:0][31:0] blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic set_vec(input int i, input string n, input logic [15:0][31:0] b,
                           input int idx, input logic [31:0] e);
        vecs[i].name = n;
        vecs[i].w    = b;
        vecs[i].idx  = idx;
        vecs[i].exp  = e;
    endtask

    // Called at posedge+1. Issues start, streams the block, collects words.
    task automatic run_block(input logic [15:0][31:0] blk, input bit stall,
                             input int abort_idx, input bit poke_start, output int recv);
        int          sent, cyc;
        logic        prev_stall;
        logic [31:0] pd;
        logic [5:0]  pi;
        sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; pd = '0; pi = '0;
        first_cyc = -1; last_cyc = -1; stab_err = 0; rdy_err = 0; aborted = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (recv < 64 && cyc < LIMIT && !aborted) begin
            in_valid = (sent < 16);
            in_data  = (sent < 16) ? blk[sent] : 32'h0;
            w_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = poke_start && (cyc == 4);
            #1;
            if (prev_stall && (!w_valid || w_data !== pd || w_idx !== pi)) stab_err++;
            if (w_valid && !w_ready && sent < 16 && in_ready) rdy_err++;
            if (abort_idx >= 0 && w_valid && w_idx == 6'(abort_idx)) begin
                clear = 1'b1;
                aborted = 1'b1;
            end else begin
                if (in_valid && in_ready) sent++;
                if (w_valid && w_ready) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    got[recv]  = w_data;
                    gidx[recv] = w_idx;
                    last_cyc   = cyc;
                    recv++;
                end
            end
            prev_stall = w_valid && !w_ready;
            pd = w_data;
            pi = w_idx;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        w_ready  = 1'b1;
        if (cyc >= LIMIT) chk("run_timeout", 32'(cyc), 32'(LIMIT - 1));
    endtask

    function automatic int model_mism(input int n);
        int m = 0;
        for (int i = 0; i < 64; i++)
            if (i >= n || got[i] !== exp_w[i] || gidx[i] !== 6'(i)) m++;
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][31:0] b;
        int n, sent, cyc;

        b = '0; b[0] = 32'h61626380; b[15] = 32'h00000018;
        set_vec(0, "abc_w16", b, 16, 32'h61626380);
        set_vec(1, "abc_w17", b, 17, 32'h000F0000);
        b = '0; b[1] = 32'h00000080;
        set_vec(2, "sigma0_w16", b, 16, 32'h00200011);
        b = '0; b[14] = 32'h00000001;
        set_vec(3, "sigma1_w16", b, 16, 32'h0000A000);
        b = '0; b[9] = 32'h12345678;
        set_vec(4, "w9_w16", b, 16, 32'h12345678);
        b = '0; b[0] = 32'hFFFFFFFF; b[9] = 32'h00000001;
        set_vec(5, "carry_w16", b, 16, 32'h00000000);

        #1;
        chk("rst_w_valid", 32'(w_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_w_idx", 32'(w_idx), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        w_ready = 1'b1;

        // in_valid while IDLE must not be accepted
        in_valid = 1'b1; in_data = 32'hCAFEF00D;
        #1;
        chk("idle_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("idle_w_valid", 32'(w_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        in_valid = 1'b0;

        for (int v = 0; v < NV; v++) begin
            compute_model(vecs[v].w);
            run_block(vecs[v].w, 1'b0, -1, 1'b0, n);
            chk({vecs[v].name, "_recv"}, 32'(n), 64);
            chk({vecs[v].name, "_value"}, got[vecs[v].idx], vecs[v].exp);
            chk({vecs[v].name, "_model"}, 32'(model_mism(n)), 0);
            chk({vecs[v].name, "_spacing"}, 32'(last_cyc - first_cyc), 32'(SPACING));
            chk({vecs[v].name, "_done"}, 32'(done), 1);
            chk({vecs[v].name, "_done_idx"}, 32'(w_idx), 63);
            chk({vecs[v].name, "_idle"}, 32'(busy), 0);
            @(posedge clk); #1;
            chk({vecs[v].name, "_done_drop"}, 32'(done), 0);
        end

        // backpressure: random stalls, same sequence, stable outputs
        compute_model(vecs[0].w);
        run_block(vecs[0].w, 1'b1, -1, 1'b0, n);
        chk("stall_recv", 32'(n), 64);
        chk("stall_model", 32'(model_mism(n)), 0);
        chk("stall_stable", 32'(stab_err), 0);
        chk("stall_in_ready", 32'(rdy_err), 0);
        chk("stall_done", 32'(done), 1);
        @(posedge clk); #1;

        // clear at w_idx 30, then a fresh block
        run_block(vecs[0].w, 1'b0, 30, 1'b0, n);
        chk("clear_hit", 32'(aborted), 1);
        chk("clear_w_valid", 32'(w_valid), 0);
        chk("clear_busy", 32'(busy), 0);
        chk("clear_done", 32'(done), 0);
        clear = 1'b0;
        @(posedge clk); #1;
        compute_model(vecs[2].w);
        run_block(vecs[2].w, 1'b0, -1, 1'b0, n);
        chk("after_clear_model", 32'(model_mism(n)), 0);
        @(posedge clk); #1;

        // start pulse while busy is ignored
        compute_model(vecs[4].w);
        run_block(vecs[4].w, 1'b0, -1, 1'b1, n);
        chk("start_busy_model", 32'(model_mism(n)), 0);
        @(posedge clk); #1;

        // asynchronous reset in the middle of EXPAND
        compute_model(vecs[0].w);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sent = 0; cyc = 0; w_ready = 1'b1;
        while (!(w_valid && w_idx >= 6'd40) && cyc < 200) begin
            in_valid = (sent < 16);
            in_data  = (sent < 16) ? vecs[0].w[sent] : 32'h0;
            #1;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("rst_mid_reach", 32'(cyc < 200), 1);
        chk("rst_mid_word", w_data, exp_w[w_idx]);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_w_valid", 32'(w_valid), 0);
        chk("rst_mid_w_data", w_data, 0);
        chk("rst_mid_w_idx", 32'(w_idx), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // fresh block after reset
        compute_model(vecs[3].w);
        run_block(vecs[3].w, 1'b0, -1, 1'b0, n);
        chk("after_rst_model", 32'(model_mism(n)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
